// File: rtl/pzcorebus_csr_responder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pzcorebus_csr_responder_pkg
//  Description : Shared command/response/state encodings for the CSR
//                responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package pzcorebus_csr_responder_pkg;

    // Command channel encoding
    typedef enum logic [1:0] {
        CMD_NULL             = 2'd0,
        CMD_READ             = 2'd1,
        CMD_WRITE            = 2'd2,
        CMD_WRITE_NON_POSTED = 2'd3
    } cmd_e;

    // Response channel encoding
    typedef enum logic [1:0] {
        RESP_NULL               = 2'd0,
        RESP_RESPONSE           = 2'd1,
        RESP_RESPONSE_WITH_DATA = 2'd2
    } resp_e;

    // Response slot state: IDLE = empty, BUSY = holds a valid response
    typedef enum logic [0:0] {
        STATE_IDLE = 1'b0,
        STATE_BUSY = 1'b1
    } state_e;

    // Fixed part of a response; id/data widths are added by the top level
    typedef struct packed {
        resp_e resp;
        logic  error;
    } resp_head_t;

endpackage : pzcorebus_csr_responder_pkg
`default_nettype wire

// File: rtl/pzcorebus_csr_responder_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pzcorebus_csr_responder_regfile
//  Description : DEPTH x DATA_WIDTH register array with one byte-enabled
//                write port and one asynchronous read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module pzcorebus_csr_responder_regfile
    import pzcorebus_csr_responder_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 64,
    parameter int                    INDEX_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
)(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_write_en,
    input  logic [INDEX_WIDTH-1:0]    i_write_index,
    input  logic [DATA_WIDTH-1:0]     i_write_data,
    input  logic [DATA_WIDTH/8-1:0]   i_write_byteen,
    input  logic [INDEX_WIDTH-1:0]    i_read_index,
    output logic [DATA_WIDTH-1:0]     o_read_data
);

    localparam int c_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    generate
        for (genvar w = 0; w < DEPTH; w++) begin : g_word
            // Byte-enabled update of one word; async reset to RESET_VALUE
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_mem[w] <= RESET_VALUE;
                end else if (i_write_en && (i_write_index == INDEX_WIDTH'(w))) begin
                    for (int b = 0; b < c_BYTES; b++) begin
                        if (i_write_byteen[b]) begin
                            r_mem[w][8*b +: 8] <= i_write_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    assign o_read_data = r_mem[i_read_index];

endmodule : pzcorebus_csr_responder_regfile
`default_nettype wire

// File: rtl/pzcorebus_csr_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pzcorebus_csr_responder
//  Description : Terminating pzcorebus CSR responder. Decodes single-beat
//                read / posted write / non-posted write commands against an
//                internal register file and returns one registered response
//                per read and non-posted write.
//  Revision    : 1.0 - initial release
// ============================================================================
module pzcorebus_csr_responder
    import pzcorebus_csr_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ID_WIDTH     = 4,
    parameter int                    DEPTH        = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
)(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [1:0]                i_mcmd,
    input  logic [ID_WIDTH-1:0]       i_mid,
    input  logic [ADDR_WIDTH-1:0]     i_maddr,
    input  logic [DATA_WIDTH-1:0]     i_mdata,
    input  logic [DATA_WIDTH/8-1:0]   i_mdata_byteen,
    output logic                      o_scmd_accept,
    output logic [1:0]                o_sresp,
    output logic [ID_WIDTH-1:0]       o_sid,
    output logic                      o_serror,
    output logic [DATA_WIDTH-1:0]     o_sdata,
    input  logic                      i_mresp_accept
);

    localparam int          c_BYTES       = DATA_WIDTH / 8;
    localparam int          c_OFFSET_BITS = $clog2(c_BYTES);
    localparam int          c_INDEX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] c_WINDOW      = 64'(DEPTH) * 64'(c_BYTES);

    typedef struct packed {
        resp_head_t             head;
        logic [ID_WIDTH-1:0]    id;
        logic [DATA_WIDTH-1:0]  data;
    } response_t;

    state_e                   r_state;
    response_t                r_response;
    response_t                w_next_response;

    cmd_e                     w_cmd;
    logic                     w_handshake;
    logic                     w_resp_handshake;
    logic                     w_write_en;
    logic [ADDR_WIDTH-1:0]    w_offset;
    logic                     w_in_range;
    logic [c_INDEX_WIDTH-1:0] w_index;
    logic [DATA_WIDTH-1:0]    w_read_data;

    assign w_cmd            = cmd_e'(i_mcmd);
    assign o_scmd_accept    = (r_state == STATE_IDLE) || i_mresp_accept;
    assign w_handshake      = (w_cmd != CMD_NULL) && o_scmd_accept;
    assign w_resp_handshake = w_handshake &&
                              ((w_cmd == CMD_READ) || (w_cmd == CMD_WRITE_NON_POSTED));

    // Wrapping subtraction; anything below the base wraps high and falls out of range
    assign w_offset   = i_maddr - BASE_ADDRESS;
    assign w_in_range = (64'(w_offset) < c_WINDOW);
    assign w_index    = w_offset[c_OFFSET_BITS +: c_INDEX_WIDTH];
    assign w_write_en = w_handshake && w_in_range &&
                        ((w_cmd == CMD_WRITE) || (w_cmd == CMD_WRITE_NON_POSTED));

    pzcorebus_csr_responder_regfile #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (DEPTH),
        .INDEX_WIDTH (c_INDEX_WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_regfile (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_write_en     (w_write_en),
        .i_write_index  (w_index),
        .i_write_data   (i_mdata),
        .i_write_byteen (i_mdata_byteen),
        .i_read_index   (w_index),
        .o_read_data    (w_read_data)
    );

    // Build the response for the command currently presented
    always_comb begin
        w_next_response            = '0;
        w_next_response.id         = i_mid;
        w_next_response.head.error = !w_in_range;
        if (w_cmd == CMD_READ) begin
            w_next_response.head.resp = RESP_RESPONSE_WITH_DATA;
            w_next_response.data      = w_in_range ? w_read_data : '0;
        end else begin
            w_next_response.head.resp = RESP_RESPONSE;
        end
    end

    // Response slot: load on a response-producing handshake, clear once consumed
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= STATE_IDLE;
            r_response <= '0;
        end else if (w_resp_handshake) begin
            r_state    <= STATE_BUSY;
            r_response <= w_next_response;
        end else if ((r_state == STATE_BUSY) && i_mresp_accept) begin
            r_state    <= STATE_IDLE;
            r_response <= '0;
        end
    end

    assign o_sresp  = r_response.head.resp;
    assign o_sid    = r_response.id;
    assign o_serror = r_response.head.error;
    assign o_sdata  = r_response.data;

endmodule : pzcorebus_csr_responder
`default_nettype wire

// File: doc/pzcorebus_csr_responder.md
Name: pzcorebus_csr_responder

Overview:
Terminating responder (slave end) for the pzcorebus CSR profile, the counterpart to the initiators and slicers that carry commands toward it.
- Accepts single-beat read, posted-write and non-posted-write commands.
- Backs them with an internal register file of DEPTH words.
- Returns one registered response per read and per non-posted write.
- Sits at the leaf of a slicer chain, typically behind pzcorebus_slicer stages.

Parameters:
ADDR_WIDTH, 16, byte address width on the command channel
DATA_WIDTH, 32, data width; power of two, multiple of 8
ID_WIDTH, 4, transaction ID width, echoed on response
DEPTH, 64, number of DATA_WIDTH registers; power of two
BASE_ADDRESS, 0, byte address of register 0; must be aligned to DEPTH*DATA_WIDTH/8
RESET_VALUE, 0, reset value of every register (DATA_WIDTH bits)

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous active-high reset
i_mcmd  input  2  command: NULL=0, READ=1, WRITE=2 (posted), WRITE_NON_POSTED=3
i_mid  input  ID_WIDTH  transaction ID
i_maddr  input  ADDR_WIDTH  byte address
i_mdata  input  DATA_WIDTH  write data
i_mdata_byteen  input  DATA_WIDTH/8  write byte enables
o_scmd_accept  output  1  command accepted this cycle when i_mcmd!=NULL
o_sresp  output  2  response: NULL=0, RESPONSE=1 (no data), RESPONSE_WITH_DATA=2
o_sid  output  ID_WIDTH  echoed i_mid
o_serror  output  1  address outside window
o_sdata  output  DATA_WIDTH  read data (0 for write responses and errors)
i_mresp_accept  input  1  master accepts response when o_sresp!=NULL

Behaviour:
- Reset (async assert, sync release):
  - all registers = RESET_VALUE; FSM = IDLE
  - o_sresp=NULL, o_sid=0, o_serror=0, o_sdata=0, o_scmd_accept=0 is not forced (it is combinational from state; see below)
- FSM IDLE (response slot empty) / BUSY (response slot holds a valid response).
- o_scmd_accept = (state==IDLE) || i_mresp_accept. Combinational; no path from i_mcmd to o_scmd_accept.
- Command handshake: i_mcmd!=NULL && o_scmd_accept.
  - On handshake, decode word index = (i_maddr - BASE_ADDRESS) >> log2(DATA_WIDTH/8).
  - In range iff the difference < DEPTH*DATA_WIDTH/8. Low address bits are ignored; no misalignment error.
- WRITE / WRITE_NON_POSTED in range:
  - Update bytes whose byteen bit is 1 at the handshake clock edge.
  - Out of range: no register change.
- READ: o_sdata captures the addressed register value before any write in the same cycle. Only one command per cycle, so no intra-cycle conflict.
- Response generation (latency exactly 1 cycle after handshake):
  - READ → RESPONSE_WITH_DATA, data=register (0 if error).
  - WRITE_NON_POSTED → RESPONSE, data=0.
  - WRITE (posted) → no response; an error is silently dropped.
- State transitions:
  - IDLE→BUSY on handshake producing a response.
  - BUSY→IDLE when i_mresp_accept and no new response-producing handshake this cycle.
  - BUSY→BUSY (response replaced) when i_mresp_accept and a new response-producing handshake occur together. This gives back-to-back throughput of 1 per cycle.
- While BUSY and !i_mresp_accept: o_sresp/o_sid/o_serror/o_sdata hold stable; commands are stalled.
- Read after write to the same address on consecutive handshakes returns the new data.
- Posted writes are accepted whenever o_scmd_accept=1 and never occupy the response slot.
- Reset mid-transaction: pending response is discarded; registers revert to RESET_VALUE.
- i_mcmd values are only sampled when o_scmd_accept=1.

Decomposition:
- pzcorebus_csr_responder_pkg:
  - command enum (NULL/READ/WRITE/WRITE_NON_POSTED)
  - response enum (NULL/RESPONSE/RESPONSE_WITH_DATA)
  - state enum (IDLE/BUSY)
  - response struct {resp, id, error, data}
- One sub-module: pzcorebus_csr_responder_regfile. DEPTH×DATA_WIDTH byte-enabled register array, one write port, one async read port, async reset to RESET_VALUE.

Test Plan:
- Reset then READ id=3 addr=0x0004 → next cycle o_sresp=2, o_sid=3, o_sdata=RESET_VALUE, o_serror=0.
- WRITE_NON_POSTED id=1 addr=0x0008 data=0xA5A5_1234 byteen=0b0011, then READ addr=0x0008 → RESPONSE id=1, then data 0x0000_1234.
- Posted WRITE addr=0x0010 data=0xDEAD_BEEF followed immediately by READ addr=0x0010 → no response for the write; read returns 0xDEAD_BEEF one cycle after its handshake.
- READ addr=0x0100 (DEPTH=64, out of range) → o_sresp=2, o_serror=1, o_sdata=0. NP write out of range → RESPONSE with o_serror=1 and registers unchanged.
- Backpressure: hold i_mresp_accept=0 for 5 cycles with a pending READ response → response signals stable and o_scmd_accept=0 throughout. Then assert accept with a new READ present → both handshakes in the same cycle, new response next cycle.
- Assert i_rst while BUSY with an unconsumed response → o_sresp=NULL immediately (async), and previously written register reads back RESET_VALUE after release.
